// File: rtl/datapath.sv
// datapath: five-stage pipelined MIPS core (F, D, E, M, W).
// Holds the instruction memory, data memory, register file, main decoder, ALU and a
// four-cycle multiplier with HI/LO. Hazard detection lives outside; this block exports
// the register/control fields it needs and takes back stall, flush and forwarding selects.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stallF, stallD      hold PC / hold IF/ID
//   forwardAD/BD        branch comparator operand: 1 = ALUOutM, 0 = register file
//   flushE              turn ID/EX into a bubble
//   forwardAE/BE        ALU operand: 00 regfile, 01 ResultW, 10 ALUOutM
//   branchD, RsD, RtD   branch type and source registers of the D instruction
//   RegWriteE .. WriteRegE, MultStartE, MultDoneE   E-stage control / register fields
//   RegWriteM, WBSrcM   M-stage control
//   RegWriteW, WriteRegW   W-stage control
//
// The instruction memory has no write port; it is preloaded with the program image
// before the first clock edge.
module datapath (
    input  logic       clk,
    input  logic       rst,
    input  logic       stallF,
    input  logic       stallD,
    input  logic       forwardAD,
    input  logic       forwardBD,
    output logic [1:0] branchD,
    output logic [4:0] RsD,
    output logic [4:0] RtD,
    input  logic       flushE,
    input  logic [1:0] forwardAE,
    input  logic [1:0] forwardBE,
    output logic       RegWriteE,
    output logic       MultStartE,
    output logic       MultDoneE,
    output logic [2:0] WBSrcE,
    output logic [4:0] RsE,
    output logic [4:0] RtE,
    output logic [4:0] WriteRegE,
    output logic       RegWriteM,
    output logic [2:0] WBSrcM,
    output logic       RegWriteW,
    output logic [4:0] WriteRegW
);
    localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpBeq = 6'h04, OpBne = 6'h05;
    localparam logic [5:0] OpAddi = 6'h08, OpLw = 6'h23, OpSw = 6'h2b;
    localparam logic [5:0] FnMfhi = 6'h10, FnMflo = 6'h12, FnMult = 6'h18;
    localparam logic [5:0] FnAdd = 6'h20, FnSub = 6'h22, FnAnd = 6'h24, FnOr = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2a;
    localparam logic [2:0] AluAdd = 3'd0, AluSub = 3'd1, AluAnd = 3'd2, AluOr = 3'd3;
    localparam logic [2:0] AluSlt = 3'd4;
    localparam logic [2:0] WbAlu = 3'b000, WbMem = 3'b001, WbHi = 3'b010, WbLo = 3'b011;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic [31:0] rf   [32];

    // ---------------- Fetch ----------------
    logic [31:0] pc_f, pc_plus4_f, instr_f, pc_next;
    assign pc_plus4_f = pc_f + 32'd4;
    assign instr_f    = imem[pc_f[7:2]];

    // ---------------- Decode ----------------
    logic [31:0] instr_d, pc_plus4_d, imm_ext_d, rd1_d, rd2_d, cmp_a_d, cmp_b_d;
    logic [31:0] pc_branch_d, pc_jump_d, result_w, alu_out_m;
    logic [5:0]  op_d, funct_d;
    logic [4:0]  rs_d, rt_d, rd_d, write_reg_d;
    logic        reg_write_d, mem_write_d, alu_src_d, reg_dst_d, mult_d, jump_d;
    logic [2:0]  wb_src_d, alu_ctrl_d;
    logic        branch_taken_d, redirect_d;

    assign op_d      = instr_d[31:26];
    assign funct_d   = instr_d[5:0];
    assign rs_d      = instr_d[25:21];
    assign rt_d      = instr_d[20:16];
    assign rd_d      = instr_d[15:11];
    assign imm_ext_d = {{16{instr_d[15]}}, instr_d[15:0]};

    always_comb begin
        reg_write_d = 1'b0;
        mem_write_d = 1'b0;
        alu_src_d   = 1'b0;
        reg_dst_d   = 1'b0;
        mult_d      = 1'b0;
        jump_d      = 1'b0;
        wb_src_d    = WbAlu;
        alu_ctrl_d  = AluAdd;
        branchD     = 2'b00;
        case (op_d)
            OpRtype: begin
                case (funct_d)
                    FnAdd:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = AluAdd; end
                    FnSub:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = AluSub; end
                    FnAnd:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = AluAnd; end
                    FnOr:   begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = AluOr;  end
                    FnSlt:  begin reg_write_d = 1'b1; reg_dst_d = 1'b1; alu_ctrl_d = AluSlt; end
                    FnMult: mult_d = 1'b1;
                    FnMfhi: begin reg_write_d = 1'b1; reg_dst_d = 1'b1; wb_src_d = WbHi; end
                    FnMflo: begin reg_write_d = 1'b1; reg_dst_d = 1'b1; wb_src_d = WbLo; end
                    default: ;
                endcase
            end
            OpAddi: begin reg_write_d = 1'b1; alu_src_d = 1'b1; end
            OpLw:   begin reg_write_d = 1'b1; alu_src_d = 1'b1; wb_src_d = WbMem; end
            OpSw:   begin mem_write_d = 1'b1; alu_src_d = 1'b1; end
            OpBeq:  branchD = 2'b01;
            OpBne:  branchD = 2'b10;
            OpJ:    jump_d = 1'b1;
            default: ;
        endcase
    end

    // Register read with write-through from W so a same-cycle write is visible in D.
    always_comb begin
        if (rs_d == 5'd0)                             rd1_d = 32'd0;
        else if (RegWriteW && (WriteRegW == rs_d))    rd1_d = result_w;
        else                                          rd1_d = rf[rs_d];
        if (rt_d == 5'd0)                             rd2_d = 32'd0;
        else if (RegWriteW && (WriteRegW == rt_d))    rd2_d = result_w;
        else                                          rd2_d = rf[rt_d];
    end

    assign cmp_a_d        = forwardAD ? alu_out_m : rd1_d;
    assign cmp_b_d        = forwardBD ? alu_out_m : rd2_d;
    assign branch_taken_d = ((branchD == 2'b01) && (cmp_a_d == cmp_b_d)) ||
                            ((branchD == 2'b10) && (cmp_a_d != cmp_b_d));
    // A stalled D instruction must not redirect: PC and IF/ID both hold instead.
    assign redirect_d     = (branch_taken_d || jump_d) && !stallD;
    assign pc_branch_d    = pc_plus4_d + {imm_ext_d[29:0], 2'b00};
    assign pc_jump_d      = {pc_plus4_d[31:28], instr_d[25:0], 2'b00};
    assign write_reg_d    = reg_dst_d ? rd_d : rt_d;

    always_comb begin
        pc_next = pc_plus4_f;
        if (redirect_d) pc_next = branch_taken_d ? pc_branch_d : pc_jump_d;
    end

    always_ff @(posedge clk) begin
        if (rst)          pc_f <= 32'd0;
        else if (!stallF) pc_f <= pc_next;
    end

    // IF/ID; a redirect squashes the slot instruction.
    always_ff @(posedge clk) begin
        if (rst || redirect_d) begin
            instr_d    <= 32'd0;
            pc_plus4_d <= 32'd0;
        end else if (!stallD) begin
            instr_d    <= instr_f;
            pc_plus4_d <= pc_plus4_f;
        end
    end

    // ---------------- Execute ----------------
    logic        reg_write_e, mem_write_e, alu_src_e, mult_e;
    logic [2:0]  wb_src_e, alu_ctrl_e;
    logic [31:0] rd1_e, rd2_e, imm_e, src_a_e, src_b_e, write_data_e, alu_out_e;
    logic [4:0]  rs_e, rt_e, write_reg_e;

    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            reg_write_e <= 1'b0;  mem_write_e <= 1'b0;  alu_src_e <= 1'b0;  mult_e <= 1'b0;
            wb_src_e    <= WbAlu; alu_ctrl_e  <= AluAdd;
            rd1_e <= 32'd0; rd2_e <= 32'd0; imm_e <= 32'd0;
            rs_e  <= 5'd0;  rt_e  <= 5'd0;  write_reg_e <= 5'd0;
        end else begin
            reg_write_e <= reg_write_d; mem_write_e <= mem_write_d; alu_src_e <= alu_src_d;
            mult_e      <= mult_d;      wb_src_e    <= wb_src_d;    alu_ctrl_e <= alu_ctrl_d;
            rd1_e <= rd1_d; rd2_e <= rd2_d; imm_e <= imm_ext_d;
            rs_e  <= rs_d;  rt_e  <= rt_d;  write_reg_e <= write_reg_d;
        end
    end

    always_comb begin
        case (forwardAE)
            2'b01:   src_a_e = result_w;
            2'b10:   src_a_e = alu_out_m;
            default: src_a_e = rd1_e;
        endcase
        case (forwardBE)
            2'b01:   write_data_e = result_w;
            2'b10:   write_data_e = alu_out_m;
            default: write_data_e = rd2_e;
        endcase
    end

    assign src_b_e = alu_src_e ? imm_e : write_data_e;

    always_comb begin
        case (alu_ctrl_e)
            AluSub:  alu_out_e = src_a_e - src_b_e;
            AluAnd:  alu_out_e = src_a_e & src_b_e;
            AluOr:   alu_out_e = src_a_e | src_b_e;
            AluSlt:  alu_out_e = {31'd0, $signed(src_a_e) < $signed(src_b_e)};
            default: alu_out_e = src_a_e + src_b_e;
        endcase
    end

    // ---------------- Multiplier / HI-LO ----------------
    logic        mult_busy_q;
    logic [1:0]  mult_cnt_q;
    logic [31:0] mult_a_q, mult_b_q, hi_q, lo_q;
    logic [63:0] product;

    // Sign-extended 64x64 product; its low 64 bits are the signed 32x32 result.
    assign product   = {{32{mult_a_q[31]}}, mult_a_q} * {{32{mult_b_q[31]}}, mult_b_q};
    // Counter reads 0..3 in the four cycles after the start cycle.
    assign MultDoneE = mult_busy_q && (mult_cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            mult_busy_q <= 1'b0;  mult_cnt_q <= 2'd0;
            mult_a_q    <= 32'd0; mult_b_q   <= 32'd0;
            hi_q        <= 32'd0; lo_q       <= 32'd0;
        end else if (MultDoneE) begin
            hi_q        <= product[63:32];
            lo_q        <= product[31:0];
            mult_busy_q <= 1'b0;
        end else if (mult_busy_q) begin
            mult_cnt_q  <= mult_cnt_q + 2'd1;
        end else if (mult_e) begin
            mult_busy_q <= 1'b1;
            mult_cnt_q  <= 2'd0;
            mult_a_q    <= src_a_e;
            mult_b_q    <= write_data_e;
        end
    end

    // ---------------- Memory ----------------
    logic        reg_write_m, mem_write_m;
    logic [2:0]  wb_src_m;
    logic [31:0] write_data_m, read_data_m;
    logic [4:0]  write_reg_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_m <= 1'b0;  mem_write_m  <= 1'b0;  wb_src_m    <= WbAlu;
            alu_out_m   <= 32'd0; write_data_m <= 32'd0; write_reg_m <= 5'd0;
        end else begin
            reg_write_m <= reg_write_e; mem_write_m  <= mem_write_e;  wb_src_m    <= wb_src_e;
            alu_out_m   <= alu_out_e;   write_data_m <= write_data_e; write_reg_m <= write_reg_e;
        end
    end

    assign read_data_m = dmem[alu_out_m[7:2]];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
        end else if (mem_write_m) begin
            dmem[alu_out_m[7:2]] <= write_data_m;
        end
    end

    // ---------------- Writeback ----------------
    logic        reg_write_w;
    logic [2:0]  wb_src_w;
    logic [31:0] alu_out_w, read_data_w;
    logic [4:0]  write_reg_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_w <= 1'b0;  wb_src_w    <= WbAlu;
            alu_out_w   <= 32'd0; read_data_w <= 32'd0; write_reg_w <= 5'd0;
        end else begin
            reg_write_w <= reg_write_m; wb_src_w    <= wb_src_m;
            alu_out_w   <= alu_out_m;   read_data_w <= read_data_m; write_reg_w <= write_reg_m;
        end
    end

    always_comb begin
        case (wb_src_w)
            WbAlu:   result_w = alu_out_w;
            WbMem:   result_w = read_data_w;
            WbHi:    result_w = hi_q;
            WbLo:    result_w = lo_q;
            default: result_w = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (reg_write_w && (write_reg_w != 5'd0)) begin
            rf[write_reg_w] <= result_w;
        end
    end

    // ---------------- Hazard-unit outputs ----------------
    assign RsD        = rs_d;
    assign RtD        = rt_d;
    assign RegWriteE  = reg_write_e;
    assign MultStartE = mult_e;
    assign WBSrcE     = wb_src_e;
    assign RsE        = rs_e;
    assign RtE        = rt_e;
    assign WriteRegE  = write_reg_e;
    assign RegWriteM  = reg_write_m;
    assign WBSrcM     = wb_src_m;
    assign RegWriteW  = reg_write_w;
    assign WriteRegW  = write_reg_w;
endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: a directed program with hand-scheduled hazard controls. Every
// register writeback is checked against a queue of expected {cycle, register, value}
// entries by an independent monitor; pipeline-control observations are checked per cycle.
module tb_datapath;
    logic       clk = 1'b0;
    logic       rst;
    logic       stallF, stallD, forwardAD, forwardBD, flushE;
    logic [1:0] forwardAE, forwardBE;
    logic [1:0] branchD;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegW;
    logic       RegWriteE, MultStartE, MultDoneE, RegWriteM, RegWriteW;
    logic [2:0] WBSrcE, WBSrcM;

    always #5 clk = ~clk;

    datapath dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
        .forwardAD(forwardAD), .forwardBD(forwardBD), .branchD(branchD),
        .RsD(RsD), .RtD(RtD), .flushE(flushE), .forwardAE(forwardAE),
        .forwardBE(forwardBE), .RegWriteE(RegWriteE), .MultStartE(MultStartE),
        .MultDoneE(MultDoneE), .WBSrcE(WBSrcE), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .RegWriteM(RegWriteM), .WBSrcM(WBSrcM),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          running = 1'b0;
    logic [31:0] prog [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] c, input logic [4:0] r, input logic [31:0] v);
        sb_q.push_back('{cyc: c, rd: r, val: v});
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    // Hazard controls scheduled by hand for the program below (cycle 0 fetches PC 0).
    task automatic drive_ctrl(input int c);
        logic stall;
        stall     = (c >= 11 && c <= 14) || (c == 20) || (c == 21);
        stallF    = stall;
        stallD    = stall;
        flushE    = stall;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = (c == 4 || c == 26) ? 2'b10 : 2'b00;
        forwardBE = (c == 4) ? 2'b01 : ((c == 5 || c == 24) ? 2'b10 : 2'b00);
    endtask

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Scoreboard monitor: every W-stage register write must match the next expectation.
    always @(negedge clk) begin
        if (running && RegWriteW === 1'b1) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write @cycle %0d: got reg %0d, expected none",
                         cyc, WriteRegW);
            end else begin
                e = sb_q.pop_front();
                chk("wb_reg", 32'(WriteRegW), 32'(e.rd));
                chk("wb_value", dut.result_w, e.val);
                chk("wb_cycle", 32'(cyc), e.cyc);
            end
        end
    end

    // Per-cycle control checks.
    always @(negedge clk) begin
        if (running) begin
            if (cyc <= 5) chk("pc_increment", dut.pc_f, 32'(cyc * 4));
            case (cyc)
                6:  chk("beq_branchD", 32'(branchD), 1);
                7:  begin
                        chk("lw_WBSrcM", 32'(WBSrcM), 1);
                        chk("beq_target_pc", dut.pc_f, 32);
                    end
                8:  chk("bne_branchD", 32'(branchD), 2);
                11: begin
                        chk("mult_start", 32'(MultStartE), 1);
                        chk("mult_not_done", 32'(MultDoneE), 0);
                    end
                12, 13, 14: begin
                        chk("mult_start_once", 32'(MultStartE), 0);
                        chk("mult_not_done", 32'(MultDoneE), 0);
                        chk("stall_bubble_E", 32'({RegWriteE, WriteRegE}), 0);
                    end
                15: begin
                        chk("mult_done", 32'(MultDoneE), 1);
                        chk("stall_bubble_E", 32'({RegWriteE, WriteRegE}), 0);
                    end
                16: begin
                        chk("mult_done_once", 32'(MultDoneE), 0);
                        chk("mflo_WBSrcE", 32'(WBSrcE), 3);
                    end
                18: chk("jump_target_pc", dut.pc_f, 64);
                20: begin
                        chk("stall_pc", dut.pc_f, 72);
                        chk("stall_RtD", 32'(RtD), 11);
                    end
                21, 22: begin
                        chk("stall_pc", dut.pc_f, 72);
                        chk("stall_RtD", 32'(RtD), 11);
                        chk("flush_E_zero", 32'({RegWriteE, WBSrcE, RsE, RtE, WriteRegE}), 0);
                    end
                23: begin
                        chk("resume_pc", dut.pc_f, 76);
                        chk("resume_RtE", 32'(RtE), 11);
                    end
                default: ;
            endcase
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);        // addi $1,$0,5
        prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);        // addi $2,$0,7
        prog[2]  = enc_r(5'd2, 5'd1, 5'd3, 6'h20);         // add  $3,$2,$1
        prog[3]  = enc_i(6'h2b, 5'd0, 5'd3, 16'd4);        // sw   $3,4($0)
        prog[4]  = enc_i(6'h23, 5'd0, 5'd4, 16'd4);        // lw   $4,4($0)
        prog[5]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);        // beq  $1,$1,+2 -> 32
        prog[6]  = enc_i(6'h08, 5'd0, 5'd5, 16'd99);       // squashed slot
        prog[7]  = enc_i(6'h08, 5'd0, 5'd5, 16'd98);       // skipped
        prog[8]  = enc_i(6'h05, 5'd1, 5'd1, 16'd5);        // bne  $1,$1 (not taken)
        prog[9]  = enc_i(6'h08, 5'd0, 5'd6, 16'd1);        // addi $6,$0,1
        prog[10] = enc_r(5'd1, 5'd2, 5'd0, 6'h18);         // mult $1,$2
        prog[11] = enc_r(5'd0, 5'd0, 5'd7, 6'h12);         // mflo $7
        prog[12] = enc_r(5'd0, 5'd0, 5'd8, 6'h10);         // mfhi $8
        prog[13] = {6'h02, 26'd16};                        // j    64
        prog[14] = enc_i(6'h08, 5'd0, 5'd9, 16'd77);       // squashed slot
        prog[15] = enc_i(6'h08, 5'd0, 5'd9, 16'd66);       // skipped
        prog[16] = enc_i(6'h08, 5'd0, 5'd10, 16'd3);       // addi $10,$0,3
        prog[17] = enc_i(6'h08, 5'd0, 5'd11, 16'd4);       // addi $11,$0,4
        prog[18] = enc_r(5'd10, 5'd11, 5'd12, 6'h20);      // add  $12,$10,$11
        prog[19] = enc_r(5'd0, 5'd1, 5'd13, 6'h22);        // sub  $13,$0,$1
        prog[20] = enc_r(5'd13, 5'd1, 5'd14, 6'h2a);       // slt  $14,$13,$1
        prog[21] = enc_r(5'd2, 5'd1, 5'd15, 6'h24);        // and  $15,$2,$1
        prog[22] = enc_r(5'd2, 5'd1, 5'd16, 6'h25);        // or   $16,$2,$1
        prog[23] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);        // addi $0,$0,9 (discarded)
        for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];

        push_exp(4,  5'd1,  32'd5);
        push_exp(5,  5'd2,  32'd7);
        push_exp(6,  5'd3,  32'd12);
        push_exp(8,  5'd4,  32'd12);
        push_exp(12, 5'd6,  32'd1);
        push_exp(18, 5'd7,  32'd35);
        push_exp(19, 5'd8,  32'd0);
        push_exp(22, 5'd10, 32'd3);
        push_exp(25, 5'd11, 32'd4);
        push_exp(26, 5'd12, 32'd7);
        push_exp(27, 5'd13, 32'hFFFF_FFFB);
        push_exp(28, 5'd14, 32'd1);
        push_exp(29, 5'd15, 32'd5);
        push_exp(30, 5'd16, 32'd7);
        push_exp(31, 5'd0,  32'd9);

        // Reset with stall and flush asserted: reset must win.
        rst       = 1'b1;
        stallF    = 1'b1;
        stallD    = 1'b1;
        flushE    = 1'b1;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_a",
            32'({branchD, RsD, RtD, RegWriteE, MultStartE, MultDoneE, WBSrcE}), 0);
        chk("reset_outputs_b",
            32'({RsE, RtE, WriteRegE, RegWriteM, WBSrcM, RegWriteW, WriteRegW}), 0);
        chk("reset_pc", dut.pc_f, 0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        running = 1'b1;
        drive_ctrl(cyc);
        while (cyc < 36) begin
            @(posedge clk);
            #1;
            drive_ctrl(cyc);
        end
        @(negedge clk);
        chk("r0_stays_zero", dut.rf[0], 0);
        chk("beq_slot_squashed", dut.rf[5], 0);
        chk("j_slot_squashed", dut.rf[9], 0);
        chk("dmem_word1", dut.dmem[1], 12);
        chk("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
